// File: rtl/intersection_phase_scheduler_if.sv
// Signal bundle between the intersection phase scheduler and its environment.
// EMERG_PREEMPT_EN adds the emergency pre-emption inputs emerg/emerg_ns.
interface intersection_phase_scheduler_if;
  logic       tick;
  logic       car_ns;
  logic       car_ew;
  logic       ped_req;
  logic [1:0] light_ns;
  logic [1:0] light_ew;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;
`ifdef EMERG_PREEMPT_EN
  logic       emerg;
  logic       emerg_ns;

  modport master (output tick, car_ns, car_ew, ped_req, emerg, emerg_ns,
                  input  light_ns, light_ew, walk, ped_pending, phase);
  modport slave  (input  tick, car_ns, car_ew, ped_req, emerg, emerg_ns,
                  output light_ns, light_ew, walk, ped_pending, phase);
`else
  modport master (output tick, car_ns, car_ew, ped_req,
                  input  light_ns, light_ew, walk, ped_pending, phase);
  modport slave  (input  tick, car_ns, car_ew, ped_req,
                  output light_ns, light_ew, walk, ped_pending, phase);
`endif
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Two-approach (NS/EW) phase scheduler with demand-driven green, yellow, all-red and pedestrian walk.
// Optional emergency pre-emption is compiled in with EMERG_PREEMPT_EN.
module intersection_phase_scheduler #(
  parameter int TW        = 5,
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 15,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 4
) (
  input logic                          clk,
  input logic                          rst,
  intersection_phase_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    ALL_RED = 3'd0,
    NS_G    = 3'd1,
    NS_Y    = 3'd2,
    EW_G    = 3'd3,
    EW_Y    = 3'd4,
    WALK    = 3'd5
`ifdef EMERG_PREEMPT_EN
    , PREEMPT = 3'd6
`endif
  } state_t;

  localparam logic [TW:0]   GMIN_E   = (TW+1)'(GREEN_MIN);
  localparam logic [TW:0]   YEL_E    = (TW+1)'(YELLOW_T);
  localparam logic [TW:0]   AR_E     = (TW+1)'(ALLRED_T);
  localparam logic [TW:0]   WALK_E   = (TW+1)'(WALK_T);
  localparam logic [TW-1:0] GSAT     = TW'(GREEN_MAX - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW:0]   elapsed;
  logic          last_ns_q, last_ns_d;
  logic          pend_q, pend_d;
  logic          hold_green;
  logic          emerg_ns_req, emerg_ew_req;
  logic [1:0]    light_ns_q, light_ns_d;
  logic [1:0]    light_ew_q, light_ew_d;
  logic          walk_q, walk_d;
  logic [2:0]    phase_q;

`ifdef EMERG_PREEMPT_EN
  logic pre_ns_q, pre_ns_d;
  assign emerg_ns_req = bus.emerg & bus.emerg_ns;
  assign emerg_ew_req = bus.emerg & ~bus.emerg_ns;
`else
  assign emerg_ns_req = 1'b0;
  assign emerg_ew_req = 1'b0;
`endif

  // Ticks elapsed in the current state, counting the present tick.
  assign elapsed = {1'b0, timer_q} + 1'b1;

  always_comb begin
    state_d    = state_q;
    last_ns_d  = last_ns_q;
    timer_d    = timer_q;
    hold_green = 1'b0;
`ifdef EMERG_PREEMPT_EN
    pre_ns_d   = pre_ns_q;
`endif
    if (bus.tick) begin
      case (state_q)
        NS_G: begin
          hold_green = 1'b1;
          if (emerg_ew_req ||
              (!emerg_ns_req && (bus.car_ew || pend_q) && elapsed >= GMIN_E)) begin
            state_d   = NS_Y;
            last_ns_d = 1'b1;
          end
        end
        EW_G: begin
          hold_green = 1'b1;
          if (emerg_ns_req ||
              (!emerg_ew_req && (bus.car_ns || pend_q) && elapsed >= GMIN_E)) begin
            state_d   = EW_Y;
            last_ns_d = 1'b0;
          end
        end
        NS_Y, EW_Y: begin
          if (elapsed == YEL_E) state_d = ALL_RED;
        end
        ALL_RED: begin
          if (elapsed == AR_E) begin
            if (pend_q)         state_d = WALK;
            else if (last_ns_q) state_d = EW_G;
            else                state_d = NS_G;
`ifdef EMERG_PREEMPT_EN
            if (bus.emerg) begin
              state_d  = PREEMPT;
              pre_ns_d = bus.emerg_ns;
            end
`endif
          end
        end
        WALK: begin
          if (emerg_ns_req || emerg_ew_req) state_d = ALL_RED;
          else if (elapsed == WALK_E)       state_d = last_ns_q ? EW_G : NS_G;
        end
`ifdef EMERG_PREEMPT_EN
        PREEMPT: begin
          hold_green = 1'b1;
          if (!bus.emerg) begin
            state_d   = pre_ns_q ? NS_Y : EW_Y;
            last_ns_d = pre_ns_q;
          end
        end
`endif
        default: state_d = ALL_RED;
      endcase

      // Green-type states may rest indefinitely, so their timer saturates.
      if (state_d != state_q)                 timer_d = '0;
      else if (hold_green && timer_q == GSAT) timer_d = timer_q;
      else                                    timer_d = timer_q + 1'b1;
    end
  end

  // A request arriving on the WALK-entry cycle is considered served.
  assign pend_d = (pend_q | bus.ped_req) & ~(state_d == WALK && state_q != WALK);

  always_comb begin
    light_ns_d = 2'b00;
    light_ew_d = 2'b00;
    walk_d     = 1'b0;
    case (state_d)
      NS_G:    light_ns_d = 2'b10;
      NS_Y:    light_ns_d = 2'b01;
      EW_G:    light_ew_d = 2'b10;
      EW_Y:    light_ew_d = 2'b01;
      WALK:    walk_d     = 1'b1;
`ifdef EMERG_PREEMPT_EN
      PREEMPT: begin
        if (pre_ns_d) light_ns_d = 2'b10;
        else          light_ew_d = 2'b10;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ALL_RED;
      timer_q    <= '0;
      last_ns_q  <= 1'b0;
      pend_q     <= 1'b0;
      light_ns_q <= 2'b00;
      light_ew_q <= 2'b00;
      walk_q     <= 1'b0;
      phase_q    <= 3'd0;
`ifdef EMERG_PREEMPT_EN
      pre_ns_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      last_ns_q  <= last_ns_d;
      pend_q     <= pend_d;
      light_ns_q <= light_ns_d;
      light_ew_q <= light_ew_d;
      walk_q     <= walk_d;
      phase_q    <= state_d;
`ifdef EMERG_PREEMPT_EN
      pre_ns_q   <= pre_ns_d;
`endif
    end
  end

  assign bus.light_ns    = light_ns_q;
  assign bus.light_ew    = light_ew_q;
  assign bus.walk        = walk_q;
  assign bus.ped_pending = pend_q;
  assign bus.phase       = phase_q;

endmodule
